// File: rtl/hyperbus_pkg.sv
// rtl/hyperbus_pkg.sv - shared types and constants for the HyperBus target
package hyperbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LATENCY,
    ST_READ,
    ST_WRITE
  } state_t;

  localparam int CA_RW    = 47;
  localparam int CA_AS    = 46;
  localparam int CA_BURST = 45;

  localparam logic [31:0] REG_ID0 = 32'h0000_0000;
  localparam logic [31:0] REG_ID1 = 32'h0000_0001;
  localparam logic [31:0] REG_CR0 = 32'h0000_0800;

  localparam logic [1:0] RWDS_LAT2X = 2'b11;
  localparam logic [1:0] RWDS_LAT1X = 2'b00;
  localparam logic [1:0] RWDS_READ  = 2'b10;

  localparam logic [15:0] CR0_RESET_DEFAULT = 16'h8F1F;

endpackage

// File: rtl/hyperbus_target_regs.sv
// rtl/hyperbus_target_regs.sv - ID0/ID1/CR0 register file and read mux
module hyperbus_target_regs
  import hyperbus_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int          ADDR_LENGTH = 32,
  parameter logic [15:0] ID0_VALUE   = 16'h0C81,
  parameter logic [15:0] CR0_RESET   = CR0_RESET_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_LENGTH-1:0] adr,
  input  logic                   we,
  input  logic [2*WIDTH-1:0]     wdat,
  output logic [2*WIDTH-1:0]     rdata
);

  logic [2*WIDTH-1:0] cr0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cr0 <= (2*WIDTH)'(CR0_RESET);
    end else if (we && adr == ADDR_LENGTH'(REG_CR0)) begin
      cr0 <= wdat;
    end
  end

  always_comb begin
    rdata = '0;
    if (adr == ADDR_LENGTH'(REG_ID0)) begin
      rdata = (2*WIDTH)'(ID0_VALUE);
    end else if (adr == ADDR_LENGTH'(REG_ID1)) begin
      rdata = '0;
    end else if (adr == ADDR_LENGTH'(REG_CR0)) begin
      rdata = cr0;
    end
  end

endmodule

// File: rtl/hyperbus_target.sv
// rtl/hyperbus_target.sv - HyperBus target bridging bursts onto a synchronous SRAM port
// Register space (ID0/ID1/CR0, zero-latency CR0 write) enabled by HBUS_TARGET_REG_SPACE_EN.
module hyperbus_target
  import hyperbus_pkg::*;
#(
  parameter int          WIDTH          = 8,
  parameter int          ADDR_LENGTH    = 32,
  parameter int          TACC_COUNT     = 5,
  parameter int          DOUBLE_LATENCY = 1,
  parameter logic [15:0] ID0_VALUE      = 16'h0C81,
  parameter logic [15:0] CR0_RESET      = CR0_RESET_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   csn_i,
  input  logic [2*WIDTH-1:0]     dq_i,
  input  logic [1:0]             rwds_i,
  output logic [2*WIDTH-1:0]     dq_o,
  output logic                   dq_oe,
  output logic [1:0]             rwds_o,
  output logic                   rwds_oe,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [1:0]             mem_be_o,
  output logic [ADDR_LENGTH-1:0] mem_adr_o,
  output logic [2*WIDTH-1:0]     mem_dat_o,
  input  logic [2*WIDTH-1:0]     mem_dat_i
);

  localparam int         LAT      = TACC_COUNT << DOUBLE_LATENCY;
  localparam logic [7:0] LAT_LAST = 8'(LAT - 1);
  localparam logic [7:0] LAT_REQ  = 8'(LAT - 2);
  localparam logic [1:0] RWDS_LAT = (DOUBLE_LATENCY != 0) ? RWDS_LAT2X : RWDS_LAT1X;
`ifdef HBUS_TARGET_REG_SPACE_EN
  localparam bit REG_EN = 1'b1;
`else
  localparam bit REG_EN = 1'b0;
`endif

  state_t                   state_q, state_d;
  logic [7:0]               cnt;
  logic                     is_read, is_reg;
  logic [28:0]              adr_hi;
  logic [ADDR_LENGTH-1:0]   adr_q;
  logic                     wr_vld;
  logic [2*WIDTH-1:0]       wr_dat;
  logic [1:0]               wr_be;
  logic [ADDR_LENGTH-1:0]   wr_adr;
  logic [2*WIDTH-1:0]       reg_rdata;
  logic                     active, rd_issue, reg_out, wr_cap;
  logic [31:0]              ca_adr;

  assign active = !csn_i;
  // Memory reads run two words ahead of the DQ output to cover the SRAM read latency.
  assign rd_issue = active && is_read && !is_reg &&
                    ((state_q == ST_LATENCY && cnt >= LAT_REQ) || state_q == ST_READ);
  assign reg_out  = active && is_reg && state_q == ST_READ;
  assign wr_cap   = active && state_q == ST_WRITE;
  assign ca_adr   = {adr_hi, dq_i[2:0]};

`ifdef HBUS_TARGET_REG_SPACE_EN
  hyperbus_target_regs #(
    .WIDTH      (WIDTH),
    .ADDR_LENGTH(ADDR_LENGTH),
    .ID0_VALUE  (ID0_VALUE),
    .CR0_RESET  (CR0_RESET)
  ) u_regs (
    .clk  (clk),
    .rst  (rst),
    .adr  (adr_q),
    .we   (wr_cap && is_reg),
    .wdat (dq_i),
    .rdata(reg_rdata)
  );
`else
  assign reg_rdata = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q != ST_IDLE && csn_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (active) state_d = ST_CA;
        ST_CA:      if (cnt == 8'd2) state_d = (REG_EN && is_reg && !is_read) ? ST_WRITE : ST_LATENCY;
        ST_LATENCY: if (cnt == LAT_LAST) state_d = is_read ? ST_READ : ST_WRITE;
        default:    state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      is_read <= 1'b0;
      is_reg  <= 1'b0;
      adr_hi  <= '0;
      adr_q   <= '0;
      wr_vld  <= 1'b0;
      wr_dat  <= '0;
      wr_be   <= '0;
      wr_adr  <= '0;
    end else begin
      wr_vld <= 1'b0;
      if (state_q == ST_IDLE) begin
        cnt <= 8'd1;
        if (active) begin
          is_read        <= dq_i[CA_RW-32];
          is_reg         <= dq_i[CA_AS-32];
          adr_hi[28:16]  <= dq_i[12:0];
        end
      end else begin
        cnt <= (state_q == ST_CA && cnt == 8'd2) ? 8'd0 : cnt + 8'd1;
        if (state_q == ST_CA && cnt == 8'd1) adr_hi[15:0] <= dq_i[15:0];
      end
      if (state_q == ST_CA && cnt == 8'd2) begin
        adr_q <= ADDR_LENGTH'(ca_adr);
      end else if (rd_issue || reg_out || wr_cap) begin
        adr_q <= adr_q + 1'b1;
      end
      if (wr_cap && !is_reg) begin
        wr_vld <= 1'b1;
        wr_dat <= dq_i;
        wr_be  <= ~rwds_i;
        wr_adr <= adr_q;
      end
    end
  end

  // A captured write word is committed even if csn_i rises in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq_o      <= '0;
      dq_oe     <= 1'b0;
      rwds_o    <= '0;
      rwds_oe   <= 1'b0;
      mem_req_o <= 1'b0;
      mem_we_o  <= 1'b0;
      mem_be_o  <= '0;
      mem_adr_o <= '0;
      mem_dat_o <= '0;
    end else begin
      dq_o      <= '0;
      dq_oe     <= 1'b0;
      rwds_o    <= '0;
      rwds_oe   <= 1'b0;
      mem_req_o <= 1'b0;
      mem_we_o  <= 1'b0;
      mem_be_o  <= '0;
      mem_adr_o <= '0;
      mem_dat_o <= '0;
      if (wr_vld) begin
        mem_req_o <= 1'b1;
        mem_we_o  <= 1'b1;
        mem_be_o  <= wr_be;
        mem_adr_o <= wr_adr;
        mem_dat_o <= wr_dat;
      end else if (rd_issue) begin
        mem_req_o <= 1'b1;
        mem_adr_o <= adr_q;
      end
      if (active && (state_q == ST_IDLE || state_q == ST_CA)) begin
        rwds_oe <= 1'b1;
        rwds_o  <= RWDS_LAT;
      end
      if (active && state_q == ST_READ) begin
        dq_oe   <= 1'b1;
        rwds_oe <= 1'b1;
        rwds_o  <= RWDS_READ;
        dq_o    <= is_reg ? reg_rdata : mem_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_hyperbus_target.sv
// tb/tb_hyperbus_target.sv - scoreboard bench for hyperbus_target (2x and 1x latency instances)
module tb_hyperbus_target;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] adr;
    logic [15:0] dat;
    logic [1:0]  be;
  } ev_t;

`ifdef HBUS_TARGET_REG_SPACE_EN
  localparam bit REG_EN = 1'b1;
`else
  localparam bit REG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csn0 = 1'b1, csn1 = 1'b1;
  logic [15:0] dq = '0;
  logic [1:0]  rwds = '0;

  logic [15:0] o_dq[2];
  logic        o_dqoe[2];
  logic [1:0]  o_rwds[2];
  logic        o_rwdsoe[2];
  logic        o_req[2];
  logic        o_we[2];
  logic [1:0]  o_be[2];
  logic [31:0] o_adr[2];
  logic [15:0] o_wdat[2];
  logic [15:0] rdat[2];

  logic [15:0] mem [0:255];
  ev_t         q_mem[2][$];
  ev_t         q_dq[2][$];
  ev_t         q_rw[2][$];
  int          tcur[2];
  int          cyc = 0;
  int          ntest = 0;
  int          nfail = 0;
  logic [15:0] wd[4];
  logic [1:0]  wm[4];
  logic [15:0] ed[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hyperbus_target u_dut0 (
    .clk(clk), .rst(rst), .csn_i(csn0), .dq_i(dq), .rwds_i(rwds),
    .dq_o(o_dq[0]), .dq_oe(o_dqoe[0]), .rwds_o(o_rwds[0]), .rwds_oe(o_rwdsoe[0]),
    .mem_req_o(o_req[0]), .mem_we_o(o_we[0]), .mem_be_o(o_be[0]),
    .mem_adr_o(o_adr[0]), .mem_dat_o(o_wdat[0]), .mem_dat_i(rdat[0])
  );

  hyperbus_target #(.DOUBLE_LATENCY(0)) u_dut1 (
    .clk(clk), .rst(rst), .csn_i(csn1), .dq_i(dq), .rwds_i(rwds),
    .dq_o(o_dq[1]), .dq_oe(o_dqoe[1]), .rwds_o(o_rwds[1]), .rwds_oe(o_rwdsoe[1]),
    .mem_req_o(o_req[1]), .mem_we_o(o_we[1]), .mem_be_o(o_be[1]),
    .mem_adr_o(o_adr[1]), .mem_dat_o(o_wdat[1]), .mem_dat_i(rdat[1])
  );

  // SRAM model shared by both targets; read data valid the cycle after the request.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (o_req[d]) begin
        if (o_we[d]) begin
          if (o_be[d][0]) mem[o_adr[d][7:0]][7:0]  <= o_wdat[d][7:0];
          if (o_be[d][1]) mem[o_adr[d][7:0]][15:8] <= o_wdat[d][15:8];
        end else begin
          rdat[d] <= mem[o_adr[d][7:0]];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        int  rel;
        ev_t e;
        rel = cyc - tcur[d];
        if (o_req[d]) begin
          ntest++;
          if (q_mem[d].size() == 0) begin
            nfail++;
            $display("FAIL dut%0d unexpected_mem_req cyc %0d we %0b adr %h", d, rel, o_we[d], o_adr[d]);
          end else begin
            e = q_mem[d].pop_front();
            if (rel != e.cyc || o_we[d] != e.we || o_adr[d] != e.adr ||
                (e.we && (o_wdat[d] != e.dat || o_be[d] != e.be))) begin
              nfail++;
              $display("FAIL dut%0d mem_access got cyc %0d we %0b adr %h dat %h be %b, want cyc %0d we %0b adr %h dat %h be %b",
                       d, rel, o_we[d], o_adr[d], o_wdat[d], o_be[d], e.cyc, e.we, e.adr, e.dat, e.be);
            end
          end
        end
        if (o_dqoe[d]) begin
          ntest++;
          if (q_dq[d].size() == 0) begin
            nfail++;
            $display("FAIL dut%0d unexpected_dq cyc %0d dq %h", d, rel, o_dq[d]);
          end else begin
            e = q_dq[d].pop_front();
            if (rel != e.cyc || o_dq[d] != e.dat || !o_rwdsoe[d] || o_rwds[d] != e.be) begin
              nfail++;
              $display("FAIL dut%0d read_data got cyc %0d dq %h rwds %b oe %0b, want cyc %0d dq %h rwds %b oe 1",
                       d, rel, o_dq[d], o_rwds[d], o_rwdsoe[d], e.cyc, e.dat, e.be);
            end
          end
        end else if (o_rwdsoe[d]) begin
          ntest++;
          if (q_rw[d].size() == 0) begin
            nfail++;
            $display("FAIL dut%0d unexpected_rwds cyc %0d rwds %b", d, rel, o_rwds[d]);
          end else begin
            e = q_rw[d].pop_front();
            if (rel != e.cyc || o_rwds[d] != e.be) begin
              nfail++;
              $display("FAIL dut%0d latency_rwds got cyc %0d rwds %b, want cyc %0d rwds %b",
                       d, rel, o_rwds[d], e.cyc, e.be);
            end
          end
        end
      end
    end
  end

  task automatic check_quiet(input int d, input string name);
    ntest++;
    if (o_dq[d] != 0 || o_dqoe[d] || o_rwds[d] != 0 || o_rwdsoe[d] || o_req[d] ||
        o_we[d] || o_be[d] != 0 || o_adr[d] != 0 || o_wdat[d] != 0) begin
      nfail++;
      $display("FAIL dut%0d %s got dq %h oe %0b rwds %b roe %0b req %0b we %0b be %b adr %h dat %h, want all 0",
               d, name, o_dq[d], o_dqoe[d], o_rwds[d], o_rwdsoe[d], o_req[d], o_we[d], o_be[d], o_adr[d], o_wdat[d]);
    end
  endtask

  // Expected events are queued up front; the bus is then driven one cycle per falling edge.
  task automatic xfer(input int d, input logic rd, input logic as, input logic [31:0] adr,
                      input int n, input int abort_at, input int rst_at);
    int          lat, wstart, endc, lim;
    logic [15:0] ca[3];
    lat    = (d == 0) ? 10 : 5;
    wstart = (!rd && as && REG_EN) ? 3 : 3 + lat;
    endc   = (abort_at >= 0) ? abort_at : (rd ? 3 + lat + n : wstart + n);
    lim    = (rst_at >= 0) ? rst_at : 1 << 30;
    ca[0]  = {rd, as, 1'b0, adr[31:19]};
    ca[1]  = adr[18:3];
    ca[2]  = {13'd0, adr[2:0]};
    for (int c = 0; c < 3; c++)
      if (c < endc && c < lim) q_rw[d].push_back('{c, 1'b0, 32'd0, 16'd0, (d == 0) ? 2'b11 : 2'b00});
    if (rd) begin
      if (!as)
        for (int k = 0; 1 + lat + k < endc && 1 + lat + k < lim; k++)
          q_mem[d].push_back('{1 + lat + k, 1'b0, adr + 32'(k), 16'd0, 2'b00});
      for (int k = 0; k < n && 3 + lat + k < endc && 3 + lat + k < lim; k++)
        q_dq[d].push_back('{3 + lat + k, 1'b0, 32'd0, ed[k], 2'b10});
    end else if (!as) begin
      for (int k = 0; k < n; k++)
        if (wstart + k < endc && wstart + k + 1 < lim)
          q_mem[d].push_back('{wstart + k + 1, 1'b1, adr + 32'(k), wd[k], ~wm[k]});
    end
    for (int c = 0; c <= endc; c++) begin
      @(negedge clk);
      if (c == 0) tcur[d] = cyc + 1;
      if (d == 0) csn0 = (c >= endc); else csn1 = (c >= endc);
      if (c < 3) begin
        dq = ca[c]; rwds = 2'b00;
      end else if (!rd && c >= wstart && c - wstart < n) begin
        dq = wd[c - wstart]; rwds = wm[c - wstart];
      end else begin
        dq = 16'h0; rwds = 2'b00;
      end
      if (rst_at >= 0 && c == rst_at) begin
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_quiet(d, "reset_mid_write");
        @(negedge clk);
        csn0 = 1'b1; csn1 = 1'b1; dq = 16'h0; rwds = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        break;
      end
    end
    csn0 = 1'b1; csn1 = 1'b1; dq = 16'h0; rwds = 2'b00;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    rdat[0] = '0; rdat[1] = '0;
    tcur[0] = 0; tcur[1] = 0;
    wm = '{2'b00, 2'b00, 2'b00, 2'b00};
    repeat (2) @(negedge clk);
    check_quiet(0, "reset_state");
    check_quiet(1, "reset_state");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    wd = '{16'hA55A, 16'h1234, 16'h0, 16'h0};
    xfer(0, 1'b0, 1'b0, 32'h10, 2, -1, -1);
    ed = '{16'hA55A, 16'h1234, 16'h0, 16'h0};
    xfer(0, 1'b1, 1'b0, 32'h10, 2, -1, -1);

    wd = '{16'hBEEF, 16'hBEEF, 16'h0, 16'h0};
    wm = '{2'b10, 2'b11, 2'b00, 2'b00};
    xfer(0, 1'b0, 1'b0, 32'h20, 2, -1, -1);
    wm = '{2'b00, 2'b00, 2'b00, 2'b00};
    ed = '{16'h00EF, 16'h0000, 16'h0, 16'h0};
    xfer(0, 1'b1, 1'b0, 32'h20, 2, -1, -1);

    xfer(0, 1'b1, 1'b0, 32'h10, 2, 4, -1);
    wd = '{16'h1111, 16'h0, 16'h0, 16'h0};
    xfer(0, 1'b0, 1'b0, 32'h40, 1, 2, -1);

    ed = '{16'hA55A, 16'h0, 16'h0, 16'h0};
    xfer(1, 1'b1, 1'b0, 32'h10, 1, -1, -1);

`ifdef HBUS_TARGET_REG_SPACE_EN
    ed = '{16'h0C81, 16'h0000, 16'h0, 16'h0};
    xfer(0, 1'b1, 1'b1, 32'h0, 2, -1, -1);
    wd = '{16'h8F17, 16'h0, 16'h0, 16'h0};
    xfer(0, 1'b0, 1'b1, 32'h800, 1, -1, -1);
    ed = '{16'h8F17, 16'h0, 16'h0, 16'h0};
    xfer(0, 1'b1, 1'b1, 32'h800, 1, -1, -1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    ed = '{16'h8F1F, 16'h0, 16'h0, 16'h0};
    xfer(0, 1'b1, 1'b1, 32'h800, 1, -1, -1);
`else
    ed = '{16'h0000, 16'h0000, 16'h0, 16'h0};
    xfer(0, 1'b1, 1'b1, 32'h0, 2, -1, -1);
    wd = '{16'h8F17, 16'h0, 16'h0, 16'h0};
    xfer(0, 1'b0, 1'b1, 32'h800, 1, -1, -1);
`endif

    wd = '{16'hA0A0, 16'hB1B1, 16'h0, 16'h0};
    xfer(0, 1'b0, 1'b0, 32'h30, 2, -1, 14);
    ed = '{16'h0000, 16'h0, 16'h0, 16'h0};
    xfer(0, 1'b1, 1'b0, 32'h30, 1, -1, -1);
    ed = '{16'hA55A, 16'h0, 16'h0, 16'h0};
    xfer(0, 1'b1, 1'b0, 32'h10, 1, -1, -1);

    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      ntest++;
      if (q_mem[d].size() != 0 || q_dq[d].size() != 0 || q_rw[d].size() != 0) begin
        nfail++;
        $display("FAIL dut%0d missing_events got pending mem %0d dq %0d rwds %0d, want 0 0 0",
                 d, q_mem[d].size(), q_dq[d].size(), q_rw[d].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/hyperbus_target.md
# hyperbus_target

Synthesizable HyperBus target (HyperRAM-style responder) that answers transactions from the HyperBus primary controller. It sits behind DDR I/O cells that present two edges per `clk` cycle as a double-width word. It decodes the 48-bit command/address, inserts initial latency, and bridges burst reads and writes onto a simple synchronous SRAM port. It is used for FPGA loopback and on-chip memory emulation.

## Interface
- `WIDTH`, 8: DQ lanes per edge; words are 2*WIDTH.
- `ADDR_LENGTH`, 32: word-address width on the memory port.
- `TACC_COUNT`, 5: initial latency in `clk` cycles for 1x latency.
- `DOUBLE_LATENCY`, 1: 1 selects fixed 2x latency (2*TACC_COUNT cycles); 0 selects 1x.
- `ID0_VALUE`, 16'h0C81: ID register 0 readback.
- `CR0_RESET`, 16'h8F1F: CR0 value after reset.
- `clk`, in, 1: clock; same clock as the primary's DDR cells.
- `rst`, in, 1: reset; one clock; asynchronous, active-high.
- `csn_i`, in, 1: chip select, active low, sampled on `clk`.
- `dq_i`, in, 2*WIDTH: captured DDR word; bits [2W-1:W] hold the first edge.
- `rwds_i`, in, 2: captured RWDS; this is the write byte mask, 1 = masked.
- `dq_o`, out, 2*WIDTH: read data word.
- `dq_oe`, out, 1: DQ drive enable.
- `rwds_o`, out, 2: RWDS drive word.
- `rwds_oe`, out, 1: RWDS drive enable.
- `mem_req_o`, out, 1: memory access strobe.
- `mem_we_o`, out, 1: 1 = write.
- `mem_be_o`, out, 2: byte enables.
- `mem_adr_o`, out, ADDR_LENGTH: word address.
- `mem_dat_o`, out, 2*WIDTH: write data.
- `mem_dat_i`, in, 2*WIDTH: read data, valid the cycle after the `mem_req_o`/`!mem_we_o` cycle.

## Operation
- States: IDLE, CA, LATENCY, READ, WRITE.
- IDLE:
  - All outputs are 0; this is also the reset value of every output.
  - A sampled `csn_i`=0 captures `dq_i` as CA word 0 and moves to CA.
- CA:
  - Captures words 1 and 2, so the CA register is {w0,w1,w2}.
  - Cycles 0..2 drive `rwds_oe`=1 with `rwds_o`=2'b11 if DOUBLE_LATENCY, else 2'b00.
- CA decode:
  - ca[47]: 1 = read.
  - ca[46]: 1 = register space.
  - ca[45]: burst type; only linear is supported, and wrapped bursts are treated as linear.
  - Word address = {ca[44:16], ca[2:0]}, zero-extended or truncated to ADDR_LENGTH.
- LATENCY:
  - Counts L = TACC_COUNT<<DOUBLE_LATENCY cycles, then moves to READ or WRITE.
  - Exception: a register-space write skips LATENCY; its data word arrives in cycle 3.
- READ:
  - Word k is driven at cycle 3+L+k with `dq_oe`=1, `rwds_oe`=1 and `rwds_o`=2'b10.
  - The target prefetches by issuing memory reads ahead so the data is continuous.
  - The address increments by 1 per word and wraps at 2^ADDR_LENGTH.
- WRITE:
  - `dq_i` word k is sampled at cycle 3+L+k.
  - In the next cycle the target issues `mem_req_o`=1, `mem_we_o`=1, `mem_be_o`=~`rwds_i`, with the captured data.
  - A word with `rwds_i`=2'b11 still issues a request, with `mem_be_o`=0.
- Termination:
  - `csn_i`=1 in any non-IDLE state returns to IDLE in the next cycle.
  - `dq_oe`/`rwds_oe` drop in that same next cycle.
  - Outstanding prefetches are discarded.
  - A write word already captured is still committed.
- `csn_i` rising during CA aborts the transaction with no memory access.
- `rst` mid-transaction forces IDLE immediately, clears all outputs, and restores CR0 to CR0_RESET.

## Timing
- Cycle 0 is the first cycle `csn_i` is sampled low.
- CA words are sampled in cycles 0, 1 and 2.
- First read data appears at cycle 3+L: cycle 13 with defaults.
- Write word 0 is sampled at cycle 3+L; its memory write is issued at cycle 4+L.
- Read prefetch: word k's `mem_req_o` is issued at cycle 1+L+k, and `dq_o` is registered from `mem_dat_i`.
- Back-to-back transactions: `csn_i` high for ≥1 cycle is required; cycle 0 may follow immediately.

## Configuration
- `HBUS_TARGET_REG_SPACE_EN` defined — register space:
  - Readable: ID0 (word address 0) = ID0_VALUE, ID1 (address 1) = 16'h0000, CR0 (address 0x800).
  - CR0 is writable with zero latency.
  - Register accesses never touch the memory port.
  - CR0 is storage only; it does not change latency.
- Macro not defined:
  - Register-space reads return all zeros with normal read timing.
  - Register-space writes are ignored (no `mem_req_o`), and the zero-latency write path is absent.

## Structure
- Shared package `hyperbus_pkg` holds:
  - the state enumeration;
  - CA bit positions (RW=47, AS=46, BURST=45);
  - register addresses (ID0, ID1, CR0);
  - RWDS latency-indication and read-strobe codes (2'b11, 2'b10);
  - the CR0_RESET default.
- Sub-module `hyperbus_target_regs` holds the ID/CR0 file and read mux; it is instantiated only under `HBUS_TARGET_REG_SPACE_EN`.

## Test plan
- Memory write then read-back:
  - Write CA (ca[47]=0), address 0x10, DOUBLE_LATENCY=1, data words 16'hA55A, 16'h1234 → `mem_we_o` writes at addresses 0x10 and 0x11.
  - Read CA (ca[47]=1), address 0x10 → `dq_o` shows 16'hA55A at cycle 13 and 16'h1234 at cycle 14, with `rwds_o`=2'b10.
- Latency indication: `rwds_o`=2'b11 in cycles 0–2 when DOUBLE_LATENCY=1, and 2'b00 with `rwds_oe`=1 when DOUBLE_LATENCY=0; with DOUBLE_LATENCY=0, first read data appears at cycle 8.
- Byte mask: write 16'hBEEF with `rwds_i`=2'b10 → `mem_be_o`=2'b01; with `rwds_i`=2'b11 → `mem_be_o`=2'b00.
- Abort: `csn_i` rises at cycle 4 of a read → `dq_oe`=0 at cycle 5, state returns to IDLE, no further `mem_req_o`.
- Register space (macro on): read ID0 → 16'h0C81; zero-latency CR0 write of 16'h8F17 at cycle 3 → CR0 read returns 16'h8F17; after `rst`, CR0 reads 16'h8F1F.
- Reset mid-write at cycle 14 → all outputs 0 within the same cycle; the next transaction decodes correctly.
